// File: rtl/bsg_cgol_ctrl_if.sv
// bsg_cgol_ctrl_if
//   Bundles every non-clock, non-reset signal of the Game-of-Life sequencer.
//   Board vectors are board_width_p*board_width_p bits wide.
//   Cell (r,c) is bit r*board_width_p+c.
//   Signal names keep the sequencer's point of view (_i into it, _o out of it).
//   slave  : the sequencer side.
//   master : the surrounding logic, i.e. the game source, the cell array
//            (board_i) and the result consumer.
interface bsg_cgol_ctrl_if #(
  parameter int board_width_p     = 32,
  parameter int max_game_length_p = 10000
);
  localparam int cells_lp       = board_width_p * board_width_p;
  localparam int lg_game_len_lp = $clog2(max_game_length_p + 1);

  logic [cells_lp-1:0]       data_i;
  logic [lg_game_len_lp-1:0] frames_i;
  logic                      v_i;
  logic                      ready_o;
  logic                      en_o;
  logic                      update_o;
  logic [cells_lp-1:0]       update_val_o;
  logic [cells_lp-1:0]       board_i;
  logic [cells_lp-1:0]       data_o;
  logic                      v_o;
  logic                      yumi_i;

  modport slave (
    input  data_i, frames_i, v_i, board_i, yumi_i,
    output ready_o, en_o, update_o, update_val_o, data_o, v_o
  );

  modport master (
    output data_i, frames_i, v_i, board_i, yumi_i,
    input  ready_o, en_o, update_o, update_val_o, data_o, v_o
  );
endinterface

// File: rtl/bsg_cgol_ctrl.sv
// bsg_cgol_ctrl
//   Per-game sequencer in front of the bsg_cgol_cell array.
//   It accepts a board and a frame count, then loads the board into the cells.
//   It then steps the cells for the clipped frame count.
//   Finally it presents the cells' board until the consumer takes it.
//   Ports:
//     clk_i   : clock, all state changes on posedge
//     reset_i : asynchronous active-high reset
//     io      : game input (data_i/frames_i/v_i/ready_o),
//               cell drive (en_o/update_o/update_val_o), cell readback
//               (board_i), result output (data_o/v_o/yumi_i)
module bsg_cgol_ctrl #(
  parameter int board_width_p     = 32,
  parameter int max_game_length_p = 10000
) (
  input logic            clk_i,
  input logic            reset_i,
  bsg_cgol_ctrl_if.slave io
);
  localparam int cells_lp       = board_width_p * board_width_p;
  localparam int lg_game_len_lp = $clog2(max_game_length_p + 1);
  localparam logic [lg_game_len_lp-1:0] max_frames_lp = lg_game_len_lp'(max_game_length_p);

  // One-hot encoding: en_o and update_o decode from distinct state bits,
  // so they can never be high together.
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    LOAD = 4'b0010,
    RUN  = 4'b0100,
    DONE = 4'b1000
  } state_e;

  state_e                    state_reg, state_next;
  logic [lg_game_len_lp-1:0] count_reg, count_next;
  logic [cells_lp-1:0]       board_reg, board_next;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      count_reg <= '0;
      board_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      board_reg <= board_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    board_next  = board_reg;
    io.ready_o  = 1'b0;
    io.en_o     = 1'b0;
    io.update_o = 1'b0;
    io.v_o      = 1'b0;
    io.data_o   = '0;
    unique case (state_reg)
      IDLE: begin
        io.ready_o = 1'b1;
        if (io.v_i) begin
          board_next = io.data_i;
          // Encodings above the maximum clip rather than wrap.
          count_next = (io.frames_i > max_frames_lp) ? max_frames_lp : io.frames_i;
          state_next = LOAD;
        end
      end
      LOAD: begin
        io.update_o = 1'b1;
        state_next  = (count_reg != '0) ? RUN : DONE;
      end
      RUN: begin
        io.en_o = 1'b1;
        // RUN is only entered with a nonzero count. The zero guard keeps the
        // counter from wrapping even if that ever stops being true.
        if (count_reg <= lg_game_len_lp'(1)) begin
          count_next = '0;
          state_next = DONE;
        end else begin
          count_next = count_reg - lg_game_len_lp'(1);
        end
      end
      DONE: begin
        // The cells are frozen here, so passing board_i through is stable.
        io.v_o    = 1'b1;
        io.data_o = io.board_i;
        if (io.yumi_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign io.update_val_o = board_reg;

  a_en_update_exclusive: assert property (
    @(posedge clk_i) disable iff (reset_i) !(io.en_o && io.update_o));

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) io.yumi_i |-> io.v_o);
endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// tb_bsg_cgol_ctrl
//   Bench for bsg_cgol_ctrl on a 5x5 board.
//   The frame-count limit is 12, so the 4-bit frame field has encodings above
//   the limit (13..15) that must clip to the limit.
//   A behavioural cell array closes the loop through board_i.
//   A scoreboard holds the expected result board and clipped frame count of
//   every accepted game.
module tb_bsg_cgol_ctrl;
  localparam int W   = 5;
  localparam int MAX = 12;
  localparam int N   = W * W;
  localparam int LG  = $clog2(MAX + 1);

  localparam logic [N-1:0] blinker_h = N'(25'h0003800);  // (2,1),(2,2),(2,3)

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bsg_cgol_ctrl_if #(.board_width_p(W), .max_game_length_p(MAX)) bus();

  bsg_cgol_ctrl #(.board_width_p(W), .max_game_length_p(MAX)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .io     (bus.slave)
  );

  // Cell array model. Reset does not clear it, like the real cells.
  logic [N-1:0] cells = '0;
  assign bus.board_i = cells;

  function automatic logic [N-1:0] life_step(input logic [N-1:0] b);
    logic [N-1:0] nb;
    int n, rr, cc;
    nb = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < W && cc >= 0 && cc < W)
              if (b[rr*W+cc]) n++;
          end
        end
        nb[r*W+c] = b[r*W+c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nb;
  endfunction

  always @(posedge clk) begin
    if (bus.update_o)  cells <= bus.update_val_o;
    else if (bus.en_o) cells <= life_step(cells);
  end

  typedef struct {
    logic [N-1:0] board;
    int           frames;
  } exp_t;
  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Entry and exit at a negedge with the DUT idle. When chain is set, the next
  // game's v_i/data are already driven during the yumi edge.
  task automatic game(input logic [N-1:0] d, input logic [LG-1:0] f, input int hold,
                      input bit chain, input logic [N-1:0] nd, input logic [LG-1:0] nf);
    exp_t e, got_e;
    int cyc, enc, updc;
    logic [N-1:0] held;
    e.frames = (int'(f) > MAX) ? MAX : int'(f);
    e.board  = d;
    for (int i = 0; i < e.frames; i++) e.board = life_step(e.board);
    bus.v_i = 1'b1; bus.data_i = d; bus.frames_i = f;
    sb.push_back(e);
    check("ready_idle", 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.v_i = 1'b0; bus.data_i = N'($urandom); bus.frames_i = LG'($urandom);
    cyc = 1; enc = 0; updc = 0;
    check("update_val_load", 64'(bus.update_val_o), 64'(d));
    while (!bus.v_o && cyc < 100) begin
      if (bus.en_o) enc++;
      if (bus.update_o) updc++;
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(e.frames + 2));
    check("en_cycles", 64'(enc), 64'(e.frames));
    check("update_cycles", 64'(updc), 64'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else begin
      got_e = sb.pop_front();
      check("data_o", 64'(bus.data_o), 64'(got_e.board));
    end
    held = bus.data_o;
    for (int h = 0; h < hold; h++) begin
      bus.v_i = (h == hold / 2);
      bus.data_i = N'($urandom);
      @(negedge clk);
      check("hold_v_o", 64'(bus.v_o), 64'd1);
      check("hold_data_o", 64'(bus.data_o), 64'(held));
      check("hold_ready_o", 64'(bus.ready_o), 64'd0);
    end
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b1;
    if (chain) begin
      bus.v_i = 1'b1; bus.data_i = nd; bus.frames_i = nf;
    end
    @(negedge clk);
    bus.yumi_i = 1'b0;
    check("post_yumi_ready", 64'(bus.ready_o), 64'd1);
    check("post_yumi_v_o", 64'(bus.v_o), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_en"}, 64'(bus.en_o), 64'd0);
    check({tag, "_update"}, 64'(bus.update_o), 64'd0);
    check({tag, "_v_o"}, 64'(bus.v_o), 64'd0);
    check({tag, "_update_val"}, 64'(bus.update_val_o), 64'd0);
    check({tag, "_data_o"}, 64'(bus.data_o), 64'd0);
  endtask

  initial begin
    logic [N-1:0] r1, r2;
    int cyc, enc, vcnt;
    bus.v_i = 1'b0; bus.data_i = '0; bus.frames_i = '0; bus.yumi_i = 1'b0;

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(negedge clk);
    rst = 1'b0;

    game(blinker_h, LG'(1), 0, 1'b0, '0, '0);
    game(blinker_h, LG'(2), 0, 1'b0, '0, '0);
    game(N'(25'h15A5A5), LG'(0), 0, 1'b0, '0, '0);
    game(blinker_h, LG'(1), 20, 1'b0, '0, '0);

    // Back-to-back at the frame limit; the second count clips.
    r1 = N'($urandom);
    r2 = N'($urandom);
    game(r1, LG'(12), 2, 1'b1, r2, LG'(15));
    game(r2, LG'(15), 0, 1'b0, '0, '0);

    // Reset during RUN after three frames.
    bus.v_i = 1'b1; bus.data_i = N'($urandom); bus.frames_i = LG'(10);
    @(posedge clk);
    @(negedge clk);
    bus.v_i = 1'b0;
    cyc = 0; enc = 0;
    while (enc < 3 && cyc < 50) begin
      if (bus.en_o) enc++;
      @(negedge clk);
      cyc++;
    end
    check("run_before_reset", 64'(bus.en_o), 64'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_midrun");
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0; enc = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.v_o) vcnt++;
      if (bus.en_o) enc++;
      @(negedge clk);
    end
    check("aborted_v_o_count", 64'(vcnt), 64'd0);
    check("aborted_en_count", 64'(enc), 64'd0);
    game(blinker_h, LG'(2), 0, 1'b0, '0, '0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
